// File: rtl/enemy_pkg.sv
// Shared constants, FSM state type and spawn-position helper for the enemy wave controller.
package enemy_pkg;

    localparam int unsigned SCREEN_X_SPAN = 590;
    localparam int unsigned SPRITE_W      = 50;
    localparam int unsigned KILL_SCORE    = 10;
    localparam logic [15:0] LFSR_SEED     = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } wave_state_t;

    // Fold raw values past the right edge back onto the screen.
    function automatic logic [9:0] spawn_x(input logic [15:0] lfsr_val);
        logic [9:0] r;
        r = lfsr_val[9:0];
        return (r >= 10'(SCREEN_X_SPAN)) ? (r - 10'd512) : r;
    endfunction

endpackage

// File: rtl/enemy_wave_ctrl_lfsr16.sv
// Free-running 16-bit maximal-length Fibonacci LFSR (taps 16,14,13,11).
module lfsr16
    import enemy_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LFSR_SEED;
        end else begin
            state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
        end
    end

endmodule

// File: rtl/enemy_wave_ctrl.sv
// Enemy wave controller: spawns, moves, scores and retires enemy slots.
// Optional build macro ENEMY_WAVE_SPEEDUP_EN makes descent speed grow with kills.
module enemy_wave_ctrl
    import enemy_pkg::*;
#(
    parameter int unsigned SLOTS      = 4,
    parameter int unsigned SPAWN_GAP  = 64,
    parameter int unsigned Y_LIMIT    = 430,
    parameter int unsigned MAX_ESCAPE = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  start,
    input  logic                  hit_valid,
    input  logic [1:0]            hit_slot,
    output logic [10*SLOTS-1:0]   enemy_x,
    output logic [10*SLOTS-1:0]   enemy_y,
    output logic [SLOTS-1:0]      active,
    output logic [15:0]           score,
    output logic [1:0]            escapes,
    output logic                  game_over
);

    localparam int unsigned CW  = $clog2(SPAWN_GAP + 1);
    localparam logic [CW-1:0] GAP = CW'(SPAWN_GAP);

    wave_state_t      state_q, state_n;
    logic [SLOTS-1:0] active_q, active_n, hit_vec;
    logic [9:0]       x_q [SLOTS];
    logic [9:0]       x_n [SLOTS];
    logic [9:0]       y_q [SLOTS];
    logic [9:0]       y_n [SLOTS];
    logic [15:0]      score_q, score_n, kills_q, kills_n;
    logic [1:0]       esc_q, esc_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [2:0]       step_q, step_n;
    logic             game_over_q;
    logic [15:0]      lfsr_state;
    logic [9:0]       y_sum;
    logic             spawn_done;
    int unsigned      esc_tot;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr_state)
    );

    always_comb begin
        state_n    = state_q;
        active_n   = active_q;
        x_n        = x_q;
        y_n        = y_q;
        score_n    = score_q;
        kills_n    = kills_q;
        esc_n      = esc_q;
        cnt_n      = cnt_q;
        hit_vec    = '0;
        y_sum      = '0;
        spawn_done = 1'b0;
        esc_tot    = 32'(esc_q);

        for (int unsigned i = 0; i < SLOTS; i++) begin
            hit_vec[i] = hit_valid && (hit_slot == 2'(i)) && active_q[i];
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_n  = ST_RUN;
                    active_n = '0;
                    score_n  = '0;
                    esc_n    = '0;
                    kills_n  = '0;
                    cnt_n    = '0;
                end
            end
            ST_RUN: begin
                if (tick) begin
                    cnt_n = (cnt_q == GAP) ? GAP : cnt_q + 1'b1;
                    for (int unsigned i = 0; i < SLOTS; i++) begin
                        if (active_q[i]) begin
                            y_sum  = y_q[i] + 10'(step_q);
                            y_n[i] = y_sum;
                            if (y_sum >= 10'(Y_LIMIT)) begin
                                active_n[i] = 1'b0;
                                if (!hit_vec[i]) begin
                                    esc_tot = esc_tot + 1;
                                end
                            end
                        end
                    end
                    // Free slots are judged on pre-cycle occupancy, so slots vacated
                    // this cycle by a hit or an escape wait for the next qualifying tick.
                    if (cnt_n == GAP) begin
                        for (int unsigned i = 0; i < SLOTS; i++) begin
                            if (!active_q[i] && !spawn_done) begin
                                spawn_done  = 1'b1;
                                active_n[i] = 1'b1;
                                x_n[i]      = spawn_x(lfsr_state);
                                y_n[i]      = '0;
                                cnt_n       = '0;
                            end
                        end
                    end
                end
                esc_n    = (esc_tot >= MAX_ESCAPE) ? 2'(MAX_ESCAPE) : 2'(esc_tot);
                active_n = active_n & ~hit_vec;
                if (|hit_vec) begin
                    kills_n = (&kills_q) ? kills_q : kills_q + 16'd1;
                    score_n = (score_q > (16'hFFFF - 16'(KILL_SCORE))) ? 16'hFFFF
                                                                       : score_q + 16'(KILL_SCORE);
                end
                if (32'(esc_n) >= MAX_ESCAPE) begin
                    state_n = ST_OVER;
                end
            end
            ST_OVER: begin
                if (start) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

`ifdef ENEMY_WAVE_SPEEDUP_EN
        step_n = 3'd1 + ((kills_n >= 16'd24) ? 3'd3 : 3'(kills_n >> 3));
`else
        step_n = 3'd1;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            active_q    <= '0;
            score_q     <= '0;
            kills_q     <= '0;
            esc_q       <= '0;
            cnt_q       <= '0;
            step_q      <= 3'd1;
            game_over_q <= 1'b0;
            for (int unsigned i = 0; i < SLOTS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            state_q     <= state_n;
            active_q    <= active_n;
            score_q     <= score_n;
            kills_q     <= kills_n;
            esc_q       <= esc_n;
            cnt_q       <= cnt_n;
            step_q      <= step_n;
            game_over_q <= (state_n == ST_OVER);
            x_q         <= x_n;
            y_q         <= y_n;
        end
    end

    always_comb begin
        enemy_x = '0;
        enemy_y = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            enemy_x[10*i +: 10] = x_q[i];
            enemy_y[10*i +: 10] = y_q[i];
        end
    end

    assign active    = active_q;
    assign score     = score_q;
    assign escapes   = esc_q;
    assign game_over = game_over_q;

endmodule

// File: doc/enemy_wave_ctrl.md
ENEMY_WAVE_CTRL -- requirements
Module: enemy_wave_ctrl

Interface
REQ-001 SHALL have parameter SLOTS, default 4, number of concurrent enemy slots.
REQ-002 SHALL have parameter SPAWN_GAP, default 64, minimum move ticks between spawns.
REQ-003 SHALL have parameter Y_LIMIT, default 430, escape row for enemy top edge.
REQ-004 SHALL have parameter MAX_ESCAPE, default 3, escapes that end the game.
REQ-005 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port tick  input  1  one-clk move strobe, synchronous to clk.
REQ-008 SHALL have port start  input  1  level; leaves IDLE or OVER.
REQ-009 SHALL have port hit_valid  input  1  one-clk pulse; collision reported on hit_slot.
REQ-010 SHALL have port hit_slot  input  2  slot index hit.
REQ-011 SHALL have port enemy_x  output  10*SLOTS  packed x per slot; slot i at [10i+9:10i].
REQ-012 SHALL have port enemy_y  output  10*SLOTS  packed y per slot, same packing.
REQ-013 SHALL have port active  output  SLOTS  slot i occupied.
REQ-014 SHALL have port score  output  16  kills*10, saturating at 16'hFFFF.
REQ-015 SHALL have port escapes  output  2  escaped-enemy count.
REQ-016 SHALL have port game_over  output  1  high in OVER state.

Function
REQ-017 SHALL implement FSM IDLE->RUN on start=1; RUN->OVER when escapes reaches MAX_ESCAPE; OVER->IDLE on start=1.
REQ-018 SHALL, on IDLE->RUN, clear active, score, escapes, kill count, spawn counter.
REQ-019 SHALL, in RUN on each tick, increment spawn counter, saturating at SPAWN_GAP.
REQ-020 SHALL spawn, on a tick with counter==SPAWN_GAP and a free slot, into lowest-index free slot: y=0, x=r>=590 ? r-512 : r, r=LFSR[9:0]; counter cleared.
REQ-021 SHALL, with no free slot, hold counter at SPAWN_GAP and spawn on first later tick with a free slot.
REQ-022 SHALL, on each tick in RUN, add step to y of every slot active before that tick; newly spawned slot not moved that tick.
REQ-023 SHALL free a slot whose updated y>=Y_LIMIT and increment escapes in the same cycle; multiple escapes in one tick all counted, saturating at MAX_ESCAPE.
REQ-024 SHALL, on hit_valid with active[hit_slot]=1 in RUN, free that slot, increment kill count, add 10 to score.
REQ-025 SHALL ignore hit_valid on an inactive slot or outside RUN.
REQ-026 SHALL, when hit and escape hit the same slot in the same cycle, count the hit only (no escape).
REQ-027 SHALL, when hit frees a slot in the spawn cycle, not spawn into that slot until the next qualifying tick.
REQ-028 SHALL freeze positions and counters in IDLE and OVER; outputs hold last values.
REQ-029 SHALL register all outputs; latency from tick/hit_valid to output change is 1 clk.
REQ-030 SHALL advance a 16-bit maximal-length LFSR (taps 16,14,13,11) every clk in all states.

Reset
REQ-031 SHALL on rst=0 asynchronously force: state IDLE, active=0, enemy_x=0, enemy_y=0, score=0, escapes=0, game_over=0, kill count=0, spawn counter=0, step=1, LFSR=16'hACE1.
REQ-032 SHALL, on reset mid-RUN, discard all slots with no escape/kill accounting.

Configuration
REQ-033 SHALL, with ENEMY_WAVE_SPEEDUP_EN defined, set step=1+min(kills/8,3) (1..4 px per tick), updated the cycle after each kill.
REQ-034 SHALL, without ENEMY_WAVE_SPEEDUP_EN, hold step at 1 permanently.

Structure
REQ-035 SHALL take SCREEN_X_SPAN (590), SPRITE_W (50), state enum, LFSR seed, KILL_SCORE (10) from shared package enemy_pkg.
REQ-036 SHALL instantiate one sub-module lfsr16 (clk, rst, 16-bit state out).

Verification
REQ-037 SHALL cover: reset, start=1, 64 ticks -> slot0 active, y=0, x<590; x equals LFSR-derived value.
REQ-038 SHALL cover: one enemy, 430 ticks, no hit -> slot freed on tick 430, escapes=1; three such -> game_over=1, state OVER.
REQ-039 SHALL cover: hit_valid, hit_slot=0, slot0 active -> active[0]=0 next clk, score=10; repeat on inactive slot -> score unchanged.
REQ-040 SHALL cover: all 4 slots full at spawn tick -> no spawn, counter held; hit slot2 -> spawn into slot2 on next tick.
REQ-041 SHALL cover: slot at y=429, hit and tick same cycle -> score+10, escapes unchanged.
REQ-042 SHALL cover: with ENEMY_WAVE_SPEEDUP_EN, 8 kills -> y advances 2 per tick; rst=0 mid-RUN -> all outputs zero immediately.
